// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM states and default sizing.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor <= 2^(WIDTH-1), so shifted fits in WIDTH bits and trial[WIDTH] is the borrow.
    always_comb begin
        shifted  = {rem, dividend_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iterative.sv
// Multi-cycle signed divider: magnitudes are divided one bit per clock, signs are
// applied in a final fix-up cycle, and completion is flagged by a one-cycle ready pulse.
module div_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    div_state_t       state_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             exc_reg;
    logic             rdy_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    // Negating the most negative value wraps to itself, which is its exact unsigned magnitude.
    assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_reg),
        .dividend_msb (dvd_reg[WIDTH-1]),
        .divisor      (dsr_reg),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
            exc_reg       <= 1'b0;
            rdy_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (ctrl_DIV) begin
                // A start always wins, aborting whatever was in flight.
                dvd_reg     <= a_abs;
                dsr_reg     <= b_abs;
                sign_q_reg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r_reg  <= data_operandA[WIDTH-1];
                rem_reg     <= '0;
                counter_reg <= '0;
                busy_reg    <= 1'b1;
                zero_reg    <= (data_operandB == '0);
                state_reg   <= (data_operandB == '0) ? DONE : RUN;
            end else begin
                case (state_reg)
                    IDLE: ;
                    RUN: begin
                        rem_reg     <= rem_next;
                        dvd_reg     <= {dvd_reg[WIDTH-2:0], q_bit};
                        counter_reg <= counter_reg + CNT_W'(1);
                        if (counter_reg == CNT_W'(WIDTH - 1)) begin
                            state_reg <= FIX;
                        end
                    end
                    FIX: begin
                        result_reg    <= sign_q_reg ? -dvd_reg : dvd_reg;
                        remainder_reg <= sign_r_reg ? -rem_reg : rem_reg;
                        exc_reg       <= 1'b0;
                        rdy_reg       <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end
                    DONE: begin
                        // Divide-by-zero spends one extra DONE cycle producing its result.
                        if (zero_reg) begin
                            result_reg    <= '0;
                            remainder_reg <= sign_r_reg ? -dvd_reg : dvd_reg;
                            exc_reg       <= 1'b1;
                            rdy_reg       <= 1'b1;
                            busy_reg      <= 1'b0;
                            zero_reg      <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = result_reg;
    assign data_remainder = remainder_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: directed vectors, restart/reset cases and random pairs.
module tb_div_iterative;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    div_iterative #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Pulse ctrl_DIV across one rising edge; returns #1 after that edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // lat = k where RDY is seen in the cycle after edge T+k; -1 on timeout.
    task automatic wait_rdy(output int lat, output int busy_low);
        lat      = -1;
        busy_low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_e, input int exp_lat);
        int lat;
        int bl;
        start_op(a, b);
        wait_rdy(lat, bl);
        $display("%s: A=%h B=%h -> q=%h r=%h exc=%0d lat=%0d",
                 tag, a, b, data_result, data_remainder, data_exception, lat);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_q"}, data_result, exp_q);
        check_val({tag, "_r"}, data_remainder, exp_r);
        check_val({tag, "_exc"}, W'(data_exception), W'(exp_e));
        check_val({tag, "_busy_rdy"}, W'(busy), '0);
        check_val({tag, "_busy_run"}, bl, '0);
        @(negedge clock);
        check_val({tag, "_rdy_pulse"}, W'(data_resultRDY), '0);
    endtask

    initial begin
        int lat;
        int bl;
        int seen;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0] mag;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_val("rst_q", data_result, '0);
        check_val("rst_r", data_remainder, '0);
        check_val("rst_exc", W'(data_exception), '0);
        check_val("rst_rdy", W'(data_resultRDY), '0);
        check_val("rst_busy", W'(busy), '0);
        reset = 1'b0;

        run_op("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op("neg_pos", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("pos_neg", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        run_op("neg_neg", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("divzero", 32'd55, 32'd0, 32'd0, 32'd55, 1'b1, 1);
        run_op("after_dz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Outputs must hold the previous result after a new start.
        start_op(32'd100, 32'd7);
        check_val("hold_q", data_result, 32'd3);
        check_val("hold_busy", W'(busy), 32'd1);
        wait_rdy(lat, bl);
        $display("hold: A=100 B=7 -> q=%h r=%h lat=%0d", data_result, data_remainder, lat);
        check_val("hold_lat", lat, 32'd33);
        check_val("hold_new_q", data_result, 32'd14);

        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op("min_by1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op("max_by_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 33);
        run_op("small_big", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33);
        run_op("zero_div", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
        run_op("negdz", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);

        // Restart mid-operation: only the second operation may signal ready.
        start_op(32'd1000, 32'd10);
        seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        start_op(32'd81, 32'd9);
        wait_rdy(lat, bl);
        $display("restart: A=81 B=9 -> q=%h r=%h lat=%0d", data_result, data_remainder, lat);
        check_val("restart_lat", lat, 32'd33);
        check_val("restart_q", data_result, 32'd9);
        check_val("restart_r", data_remainder, 32'd0);
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check_val("restart_extra_rdy", seen, 32'd0);

        // Asynchronous reset mid-operation.
        run_op("pre_rst", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        start_op(32'd1000, 32'd7);
        repeat (19) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        $display("midreset: q=%h r=%h exc=%0d rdy=%0d busy=%0d",
                 data_result, data_remainder, data_exception, data_resultRDY, busy);
        check_val("mrst_q", data_result, '0);
        check_val("mrst_r", data_remainder, '0);
        check_val("mrst_busy", W'(busy), '0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) seen++;
        end
        check_val("mrst_no_rdy", seen, 32'd0);

        // Random signed pairs against the language's truncating / and %.
        for (int i = 0; i < 1000; i++) begin
            sa  = $urandom;
            mag = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(1, 20));
            sb  = ($urandom_range(0, 1) != 0) ? -mag : mag;
            if (sb == 0) sb = 1;
            if (sa == 32'sh8000_0000 && sb == -1) sb = 3;
            start_op(sa, sb);
            wait_rdy(lat, bl);
            $display("rnd%0d: A=%h B=%h -> q=%h r=%h lat=%0d",
                     i, sa, sb, data_result, data_remainder, lat);
            check_val("rnd_lat", lat, 32'd33);
            check_val("rnd_q", data_result, sa / sb);
            check_val("rnd_r", data_remainder, sa % sb);
            check_val("rnd_ident", data_result * sb + data_remainder, sa);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_iterative.md
Name: div_iterative

Overview:
- Multi-cycle signed integer divider for the ALU execute path.
- Its quotient output feeds the ALU result mux, which drives the zero-detect flag logic downstream.
- One restoring-division step per clock; the operation is started by a one-cycle control pulse.
- Signals completion with a one-cycle ready pulse and flags divide-by-zero as an exception.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits. Must be ≥4.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- ctrl_DIV  input  1  start pulse; operands are sampled on the edge where this is high
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  quotient, two's complement
- data_remainder  output  WIDTH  remainder, two's complement
- data_exception  output  1  high with the result when the divisor was zero
- data_resultRDY  output  1  one-cycle pulse: result, remainder and exception valid
- busy  output  1  high while an operation is in progress

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; counter=0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
  - In-flight operation is discarded; no RDY pulse follows.
- States: IDLE, RUN, FIX, DONE.
- Start edge T (ctrl_DIV=1, any state):
  - Latch |A| and |B| into the dividend and divisor registers.
  - Latch sign_q = A[MSB]^B[MSB] and sign_r = A[MSB].
  - Clear the partial remainder; counter=0.
  - If B==0 go to DONE with the zero-divide flag set; otherwise go to RUN.
  - busy=1 from the cycle after T.
- RUN, one restoring step per edge:
  - Shift the {rem, dividend} pair left by 1.
  - Trial = rem − divisor (WIDTH+1 bits). If trial ≥ 0, rem = trial and the quotient LSB is 1; else the quotient LSB is 0.
  - counter++. After WIDTH steps (counter==WIDTH−1 on that edge) go to FIX.
- FIX, one edge:
  - data_result = sign_q ? −q : q.
  - data_remainder = sign_r ? −r : r.
  - data_exception=0; go to DONE.
- DONE, one cycle:
  - data_resultRDY=1; busy=0.
  - For divide-by-zero: data_result=0, data_remainder=A as latched, data_exception=1.
  - Next edge: IDLE, RDY=0.
- Latency:
  - Normal operation: RDY is high in the cycle after edge T+WIDTH+1, i.e. 33 cycles after start for WIDTH=32.
  - Divide-by-zero: RDY is high in the cycle after edge T+1.
- Output hold: data_result, data_remainder and data_exception hold their values until the next FIX/DONE write. They are not cleared on the next start.
- Rounding: truncation toward zero; the remainder takes the sign of the dividend.
- Overflow: (−2^(WIDTH−1))/(−1) yields quotient 0x80000000 and remainder 0, with data_exception=0 (wraps; no trap).
  - |−2^(WIDTH−1)| must be computed as an unsigned WIDTH-bit value, which is exact.
- Restart: ctrl_DIV high while busy, or in the DONE cycle, aborts the current operation and restarts with the new operands. No RDY pulse is produced for the aborted operation.
- Operand inputs are ignored except on the start edge.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, RUN, FIX, DONE};
  - DIV_WIDTH=32;
  - DIV_CNT_W=$clog2(DIV_WIDTH).
- Sub-module div_step (combinational):
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in the datapath.
- The top level holds the FSM, counter, sign logic and output registers.

Test Plan:
- A=100, B=7, pulse ctrl_DIV → 33 cycles later RDY=1 for exactly 1 cycle; result=14, remainder=2, exception=0; busy=1 throughout.
- A=−100, B=7 → result=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). A=100, B=−7 → result=−14, remainder=2.
- A=55, B=0 → RDY in the cycle after edge T+1; exception=1, result=0, remainder=55. Then A=9, B=3 → exception=0, result=3.
- A=0x80000000, B=0xFFFFFFFF → result=0x80000000, remainder=0, exception=0. A=0x80000000, B=1 → result=0x80000000.
- Restart: start 1000/10, re-pulse ctrl_DIV at cycle 10 with 81/9 → exactly one RDY pulse, 33 cycles after the second start, result=9. Reset mid-operation at cycle 20 → all outputs 0 immediately (asynchronously), no RDY thereafter.
- Random signed pairs (≥1000, B≠0) versus a reference model: result and remainder match, and q*B + r == A for every pair.
